// File: rtl/vram_host_port.sv
// Host register window (ADDR/DATA/INCR/STATUS) onto 64K x 16 VRAM; one access in flight at a time.
// VRAM is touched only in blit_cycle_i grant slots; host accesses that need VRAM while busy are dropped and set err.
module vram_host_port (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        blit_cycle_i,
   input  logic        reg_wr_i,
   input  logic        reg_rd_i,
   input  logic [1:0]  reg_num_i,
   input  logic [15:0] reg_data_i,
   output logic [15:0] reg_data_o,
   output logic        busy_o,
   output logic        vram_sel_o,
   output logic        vram_wr_o,
   output logic [15:0] vram_addr_o,
   output logic [15:0] vram_data_o,
   input  logic [15:0] vram_data_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_WR_PEND, ST_RD_PEND, ST_RD_DATA} state_t;

   localparam logic [1:0] REG_ADDR   = 2'd0;
   localparam logic [1:0] REG_DATA   = 2'd1;
   localparam logic [1:0] REG_INCR   = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   state_t      r_state;
   logic [15:0] r_addr;
   logic [15:0] r_incr;
   logic [15:0] r_rd_buf;
   logic [15:0] r_reg_data;
   logic [15:0] r_vram_addr;
   logic [15:0] r_vram_data;
   logic        r_err;

   logic        w_busy;
   logic        w_pend;
   logic [15:0] w_addr_next;

   assign w_busy      = (r_state != ST_IDLE);
   assign w_pend      = (r_state == ST_WR_PEND) || (r_state == ST_RD_PEND);
   assign w_addr_next = r_addr + r_incr;

   // Strobe is gated by reset as well so an abandoned access cannot glitch out.
   assign vram_sel_o  = blit_cycle_i && w_pend && !reset_i;
   assign vram_wr_o   = (r_state == ST_WR_PEND);
   assign busy_o      = w_busy;
   assign reg_data_o  = r_reg_data;
   assign vram_addr_o = r_vram_addr;
   assign vram_data_o = r_vram_data;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         r_state     <= ST_IDLE;
         r_addr      <= 16'h0000;
         r_incr      <= 16'h0001;
         r_rd_buf    <= 16'h0000;
         r_reg_data  <= 16'h0000;
         r_vram_addr <= 16'h0000;
         r_vram_data <= 16'h0000;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            ST_WR_PEND: if (blit_cycle_i) r_state <= ST_IDLE;
            ST_RD_PEND: if (blit_cycle_i) r_state <= ST_RD_DATA;
            ST_RD_DATA: begin
               r_rd_buf <= vram_data_i;
               r_state  <= ST_IDLE;
            end
            default: ;
         endcase

         // Host side only launches accesses from IDLE, so it never fights the FSM above.
         if (reg_wr_i) begin
            case (reg_num_i)
               REG_ADDR: begin
                  if (w_busy) begin
                     r_err <= 1'b1;
                  end else begin
                     r_addr      <= reg_data_i;
                     r_vram_addr <= reg_data_i;
                     r_state     <= ST_RD_PEND;
                  end
               end
               REG_DATA: begin
                  if (w_busy) begin
                     r_err <= 1'b1;
                  end else begin
                     r_vram_addr <= r_addr;
                     r_vram_data <= reg_data_i;
                     r_addr      <= w_addr_next;
                     r_state     <= ST_WR_PEND;
                  end
               end
               REG_INCR: begin
                  if (w_busy) r_err <= 1'b1;
                  else        r_incr <= reg_data_i;
               end
               default: ;
            endcase
         end else if (reg_rd_i) begin
            case (reg_num_i)
               REG_ADDR: r_reg_data <= r_addr;
               REG_DATA: begin
                  if (w_busy) begin
                     r_err <= 1'b1;
                  end else begin
                     r_reg_data  <= r_rd_buf;
                     r_addr      <= w_addr_next;
                     r_vram_addr <= w_addr_next;
                     r_state     <= ST_RD_PEND;
                  end
               end
               REG_INCR: r_reg_data <= r_incr;
               default: begin
                  r_reg_data <= {14'b0, r_err, w_busy};
                  r_err      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_vram_host_port.sv
// Bench for vram_host_port: behavioural VRAM, register-level reference model, directed and random host traffic.
module tb_vram_host_port;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        blit_cycle_i;
   logic        reg_wr_i;
   logic        reg_rd_i;
   logic [1:0]  reg_num_i;
   logic [15:0] reg_data_i;
   logic [15:0] reg_data_o;
   logic        busy_o;
   logic        vram_sel_o;
   logic        vram_wr_o;
   logic [15:0] vram_addr_o;
   logic [15:0] vram_data_o;
   logic [15:0] vram_data_i;

   int checks = 0;
   int errors = 0;

   vram_host_port dut (
      .clk          (clk),
      .reset_i      (reset_i),
      .blit_cycle_i (blit_cycle_i),
      .reg_wr_i     (reg_wr_i),
      .reg_rd_i     (reg_rd_i),
      .reg_num_i    (reg_num_i),
      .reg_data_i   (reg_data_i),
      .reg_data_o   (reg_data_o),
      .busy_o       (busy_o),
      .vram_sel_o   (vram_sel_o),
      .vram_wr_o    (vram_wr_o),
      .vram_addr_o  (vram_addr_o),
      .vram_data_o  (vram_data_o),
      .vram_data_i  (vram_data_i)
   );

   always #5 clk = ~clk;

   // Behavioural VRAM: unwritten words read back as a fixed address-derived pattern.
   logic [15:0] vmem [0:65535];
   logic        bd_init;
   logic        bd_we;
   logic [15:0] bd_addr;
   logic [15:0] bd_data;
   int          wr_count = 0;
   int          sel_count = 0;
   int          viol_cnt = 0;

   function automatic logic [15:0] dflt(input int a);
      return 16'(a) ^ 16'h5A5A;
   endfunction

   always @(posedge clk) begin
      if (bd_init)
         for (int i = 0; i < 65536; i++) vmem[i] <= dflt(i);
      if (bd_we) vmem[bd_addr] <= bd_data;
      if (vram_sel_o) begin
         sel_count <= sel_count + 1;
         if (vram_wr_o) begin
            vmem[vram_addr_o] <= vram_data_o;
            wr_count <= wr_count + 1;
         end else begin
            vram_data_i <= vmem[vram_addr_o];
         end
      end
   end

   always @(negedge clk) begin
      #3;
      if (vram_sel_o && !blit_cycle_i) viol_cnt <= viol_cnt + 1;
   end

   // Grant generator: 0 = continuous, 1 = fetch pattern 0,0,1,1, 2 = random, 3 = held off.
   int blit_mode = 0;
   initial begin
      int ph = 0;
      blit_cycle_i = 1'b1;
      forever begin
         @(negedge clk);
         ph++;
         case (blit_mode)
            0:       blit_cycle_i = 1'b1;
            1:       blit_cycle_i = ((ph % 4) >= 2);
            2:       blit_cycle_i = 1'($urandom_range(0, 1));
            default: blit_cycle_i = 1'b0;
         endcase
      end
   end

   // Reference model of the register file and memory contents.
   logic [15:0] m_addr, m_incr, m_rdbuf;
   logic        m_err;
   logic [15:0] exp_mem [int];
   logic [15:0] wq [$];

   function automatic logic [15:0] exp_rd(input logic [15:0] a);
      return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : dflt(int'(a));
   endfunction

   task automatic model_reset();
      m_addr = 16'h0000; m_incr = 16'h0001; m_rdbuf = 16'h0000; m_err = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic host_wr(input logic [1:0] num, input logic [15:0] d);
      @(negedge clk); #1;
      reg_wr_i = 1'b1; reg_num_i = num; reg_data_i = d;
      @(negedge clk); #1;
      reg_wr_i = 1'b0;
   endtask

   task automatic host_rd(input logic [1:0] num, output logic [15:0] d);
      @(negedge clk); #1;
      reg_rd_i = 1'b1; reg_num_i = num;
      @(negedge clk); #1;
      reg_rd_i = 1'b0;
      d = reg_data_o;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_o === 1'b1 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk(tag, 32'(busy_o), 32'd0);
   endtask

   task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk); #1;
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(negedge clk); #1;
      bd_we = 1'b0;
      exp_mem[int'(a)] = d;
   endtask

   task automatic op_addr_wr(input logic [15:0] v);
      host_wr(2'd0, v);
      m_addr = v;
      m_rdbuf = exp_rd(v);
      wait_idle("addr_wr_idle");
   endtask

   task automatic op_incr_wr(input logic [15:0] v);
      host_wr(2'd2, v);
      m_incr = v;
      wait_idle("incr_wr_idle");
   endtask

   task automatic op_data_wr(input logic [15:0] v);
      host_wr(2'd1, v);
      exp_mem[int'(m_addr)] = v;
      wq.push_back(m_addr);
      m_addr = m_addr + m_incr;
      wait_idle("data_wr_idle");
   endtask

   task automatic op_data_rd(input string tag, output logic [15:0] d);
      host_rd(2'd1, d);
      chk(tag, 32'(d), 32'(m_rdbuf));
      m_addr = m_addr + m_incr;
      m_rdbuf = exp_rd(m_addr);
      wait_idle("data_rd_idle");
   endtask

   task automatic op_reg_rd(input logic [1:0] num, input logic exp_busy, input string tag,
                            output logic [15:0] d);
      logic [15:0] e;
      host_rd(num, d);
      case (num)
         2'd0:    e = m_addr;
         2'd2:    e = m_incr;
         default: begin e = {14'b0, m_err, exp_busy}; m_err = 1'b0; end
      endcase
      chk(tag, 32'(d), 32'(e));
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] d;
      int s0, w0, k;
      logic [15:0] a_pend;

      reset_i = 1'b1; reg_wr_i = 1'b0; reg_rd_i = 1'b0; reg_num_i = 2'd0; reg_data_i = 16'h0;
      bd_init = 1'b1; bd_we = 1'b0; bd_addr = 16'h0; bd_data = 16'h0;
      model_reset();
      @(negedge clk); #1;
      bd_init = 1'b0;
      chk("rst_reg_data", 32'(reg_data_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_sel", 32'(vram_sel_o), 32'h0);
      chk("rst_wr", 32'(vram_wr_o), 32'h0);
      chk("rst_vaddr", 32'(vram_addr_o), 32'h0);
      chk("rst_vdata", 32'(vram_data_o), 32'h0);
      @(negedge clk); #1;
      reset_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("no_prefetch_busy", 32'(busy_o), 32'h0);
      chk("no_prefetch_sel", 32'(sel_count), 32'h0);

      // Sequential writes
      op_addr_wr(16'h1000);
      op_incr_wr(16'h0001);
      op_data_wr(16'hABCD);
      op_data_wr(16'h1234);
      chk("mem_1000", 32'(vmem[16'h1000]), 32'hABCD);
      chk("mem_1001", 32'(vmem[16'h1001]), 32'h1234);
      op_reg_rd(2'd0, 1'b0, "addr_after_seq", d);
      chk("addr_1002", 32'(d), 32'h1002);

      // Asynchronous reset mid-cycle
      @(negedge clk); #2;
      reset_i = 1'b1;
      #1;
      chk("arst_reg_data", 32'(reg_data_o), 32'h0);
      chk("arst_vaddr", 32'(vram_addr_o), 32'h0);
      chk("arst_vdata", 32'(vram_data_o), 32'h0);
      chk("arst_busy", 32'(busy_o), 32'h0);
      @(negedge clk); #1;
      reset_i = 1'b0;
      model_reset();
      op_reg_rd(2'd2, 1'b0, "incr_after_rst", d);
      chk("incr_0001", 32'(d), 32'h0001);
      op_reg_rd(2'd3, 1'b0, "status_after_rst", d);
      chk("status_0000", 32'(d), 32'h0000);
      op_data_rd("rdbuf_after_rst", d);
      chk("rdbuf_zero", 32'(d), 32'h0000);

      // Grant gating: strobe issued in a no-grant cycle
      blit_mode = 1;
      k = 0;
      do begin
         @(negedge clk); #1;
         k++;
      end while (blit_cycle_i !== 1'b0 && k < 8);
      s0 = sel_count; w0 = wr_count;
      reg_wr_i = 1'b1; reg_num_i = 2'd1; reg_data_i = 16'hBEEF;
      @(negedge clk); #1;
      reg_wr_i = 1'b0;
      exp_mem[int'(m_addr)] = 16'hBEEF;
      wq.push_back(m_addr);
      m_addr = m_addr + m_incr;
      wait_idle("gate_idle");
      chk("gate_one_sel", 32'(sel_count - s0), 32'd1);
      chk("gate_one_wr", 32'(wr_count - w0), 32'd1);
      chk("gate_mem", 32'(vmem[16'h0001]), 32'hBEEF);

      // Prefetch reads
      blit_mode = 0;
      bd_write(16'h2000, 16'h5555);
      bd_write(16'h2003, 16'h7777);
      op_addr_wr(16'h2000);
      op_incr_wr(16'h0003);
      op_data_rd("prefetch_1", d);
      chk("prefetch_5555", 32'(d), 32'h5555);
      op_data_rd("prefetch_2", d);
      chk("prefetch_7777", 32'(d), 32'h7777);
      op_reg_rd(2'd0, 1'b0, "addr_after_rd", d);
      chk("addr_2006", 32'(d), 32'h2006);

      // Address wrap, including incr = -1
      op_addr_wr(16'hFFFF);
      op_incr_wr(16'h0002);
      op_data_wr(16'h0F0F);
      chk("wrap_mem_ffff", 32'(vmem[16'hFFFF]), 32'h0F0F);
      op_reg_rd(2'd0, 1'b0, "wrap_addr", d);
      chk("wrap_addr_0001", 32'(d), 32'h0001);
      op_incr_wr(16'hFFFF);
      op_data_wr(16'hC3C3);
      chk("wrap_mem_0001", 32'(vmem[16'h0001]), 32'hC3C3);
      op_reg_rd(2'd0, 1'b0, "dec_addr", d);
      chk("dec_addr_0000", 32'(d), 32'h0000);

      // Collision while an access is held pending
      blit_mode = 3;
      op_incr_wr(16'h0001);
      host_wr(2'd1, 16'h1111);
      exp_mem[int'(m_addr)] = 16'h1111;
      wq.push_back(m_addr);
      m_addr = m_addr + m_incr;
      host_wr(2'd1, 16'h2222);
      m_err = 1'b1;
      chk("coll_busy", 32'(busy_o), 32'd1);
      op_reg_rd(2'd3, 1'b1, "coll_status", d);
      chk("coll_status_0003", 32'(d), 32'h0003);
      op_reg_rd(2'd0, 1'b1, "coll_addr_rd", d);
      blit_mode = 0;
      wait_idle("coll_idle");
      op_reg_rd(2'd3, 1'b0, "coll_status_clr", d);
      chk("coll_status_0000", 32'(d), 32'h0000);
      chk("coll_mem", 32'(vmem[16'h0000]), 32'h1111);
      chk("coll_mem_next", 32'(vmem[16'h0001]), 32'(exp_rd(16'h0001)));

      // Reset with an uncommitted write pending
      blit_mode = 3;
      a_pend = m_addr;
      host_wr(2'd1, 16'h9999);
      repeat (3) @(negedge clk);
      #1;
      chk("pend_busy", 32'(busy_o), 32'd1);
      w0 = wr_count;
      @(negedge clk); #2;
      reset_i = 1'b1;
      #1;
      chk("pend_rst_busy", 32'(busy_o), 32'd0);
      chk("pend_rst_sel", 32'(vram_sel_o), 32'd0);
      blit_mode = 0;
      repeat (2) @(negedge clk);
      #1;
      reset_i = 1'b0;
      model_reset();
      repeat (4) @(negedge clk);
      #1;
      chk("pend_no_write", 32'(wr_count - w0), 32'd0);
      chk("pend_mem_kept", 32'(vmem[a_pend]), 32'(exp_rd(a_pend)));

      // Randomized traffic against the model
      blit_mode = 2;
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 6))
            0: op_addr_wr(16'($urandom));
            1: op_incr_wr(16'($urandom_range(0, 7)) - 16'd3);
            2, 3: op_data_wr(16'($urandom));
            4: op_data_rd("rnd_data_rd", d);
            5: op_reg_rd(2'd0, 1'b0, "rnd_addr_rd", d);
            default: op_reg_rd(2'($urandom_range(2, 3)), 1'b0, "rnd_reg_rd", d);
         endcase
      end
      repeat (2) @(negedge clk);
      foreach (wq[i]) chk("rnd_mem", 32'(vmem[wq[i]]), 32'(exp_rd(wq[i])));
      chk("sel_only_in_grant", 32'(viol_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
